// File: rtl/piso_frame_tx.sv
// Serial frame transmitter: FIFO-buffered parallel words serialised as
// start bit, data bits, optional parity, then one or two stop bits.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | line high, waiting for a queued word
// S_START  | word loaded; start bit driven on the next edge
// S_DATA   | data bits shifted out, MSB or LSB first
// S_PARITY | parity bit driven on the next edge
// S_STOP   | stop bit(s) driven; chains directly into the next frame
module piso_frame_tx #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int LSB_FIRST  = 0
) (
    input  logic                            sr_clk_i,
    input  logic                            rst_i,
    input  logic [DATA_W-1:0]               data_i,
    input  logic                            valid_i,
    output logic                            ready_o,
    output logic                            data_o,
    output logic                            busy_o,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head;

    state_t            state_q;
    logic              data_o_q;
    logic              busy_o_q;
    logic [DATA_W-1:0] shift_q;
    logic              par_q;
    logic [BIT_W-1:0]  bit_cnt_q;
    logic              stop_cnt_q;

    assign ready_o      = (count_q < CNT_W'(FIFO_DEPTH));
    assign push         = valid_i && ready_o;
    assign head         = mem_q[rd_ptr_q];
    assign fifo_count_o = count_q;
    assign data_o       = data_o_q;
    assign busy_o       = busy_o_q;

    always_comb begin
        pop = 1'b0;
        if (count_q != '0) begin
            if (state_q == S_IDLE)
                pop = 1'b1;
            else if (state_q == S_STOP && stop_cnt_q == 1'b0)
                pop = 1'b1;
        end
    end

    // Pointers are PTR_W wide, so they wrap modulo the power-of-two depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push)
            wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)
            rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge sr_clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge sr_clk_i) begin
        if (push)
            mem_q[wr_ptr_q] <= data_i;
    end

    // The line register is written on the edge that leaves a state, so each
    // state's bit appears one cycle after the state is entered.
    always_ff @(posedge sr_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            data_o_q   <= 1'b1;
            busy_o_q   <= 1'b0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
        end else begin
            busy_o_q <= (state_q != S_IDLE);
            unique case (state_q)
                S_IDLE: begin
                    data_o_q <= 1'b1;
                    if (pop) begin
                        shift_q <= head;
                        par_q   <= (^head) ^ 1'(PARITY_ODD);
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    data_o_q  <= 1'b0;
                    bit_cnt_q <= BIT_W'(DATA_W - 1);
                    state_q   <= S_DATA;
                end
                S_DATA: begin
                    if (LSB_FIRST != 0) begin
                        data_o_q <= shift_q[0];
                        shift_q  <= shift_q >> 1;
                    end else begin
                        data_o_q <= shift_q[DATA_W-1];
                        shift_q  <= shift_q << 1;
                    end
                    if (bit_cnt_q == '0) begin
                        stop_cnt_q <= 1'(STOP_BITS - 1);
                        state_q    <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_q <= bit_cnt_q - 1'b1;
                    end
                end
                S_PARITY: begin
                    data_o_q   <= par_q;
                    stop_cnt_q <= 1'(STOP_BITS - 1);
                    state_q    <= S_STOP;
                end
                S_STOP: begin
                    data_o_q <= 1'b1;
                    if (stop_cnt_q == 1'b0) begin
                        if (pop) begin
                            shift_q <= head;
                            par_q   <= (^head) ^ 1'(PARITY_ODD);
                            state_q <= S_START;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        stop_cnt_q <= 1'b0;
                    end
                end
                default: begin
                    data_o_q <= 1'b1;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

endmodule
